// File: rtl/dct_pkg.sv
// dct_pkg: shared widths and types for the DCT datapath (row stage, column stage, coefficient FIFO)
package dct_pkg;
  localparam int DCT_OUT_W  = 36;
  localparam int DCT_ROWS   = 4;
  localparam int DCT_GROWTH = 3;
  typedef logic [1:0] row_idx_t;
  function automatic int dct_acc_w(input int in_w);
    return in_w + DCT_GROWTH;
  endfunction
endpackage

// File: rtl/dct4_butterfly.sv
// dct4_butterfly: one half of the 4-point transform; sum/difference stage or weighted output stage
module dct4_butterfly #(
  parameter int W         = 17,
  parameter bit OUT_STAGE = 1'b0
) (
  input  logic signed [W-1:0] a [4],
  output logic signed [W-1:0] b [4]
);
  // output stage expects a = {s0, s1, d0, d1}
  always_comb begin
    b[0] = OUT_STAGE ? a[0] + a[1] : a[0] + a[3];
    b[1] = OUT_STAGE ? (a[2] <<< 1) + a[3] : a[1] + a[2];
    b[2] = OUT_STAGE ? a[0] - a[1] : a[0] - a[3];
    b[3] = OUT_STAGE ? a[2] - (a[3] <<< 1) : a[1] - a[2];
  end
endmodule

// File: rtl/dct4_row_stage.sv
// dct4_row_stage: elastic two-stage 4-point integer DCT row transform with row/block tracking
module dct4_row_stage
  import dct_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = DCT_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  x0,
  input  logic signed [IN_W-1:0]  x1,
  input  logic signed [IN_W-1:0]  x2,
  input  logic signed [IN_W-1:0]  x3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3,
  output row_idx_t                row_idx,
  output logic                    block_done
);
  localparam int S_W = IN_W + 1;
  localparam int Y_W = dct_acc_w(IN_W);
  logic                  r_v1;
  logic                  r_v2;
  logic                  r_done;
  row_idx_t              r_cnt;
  logic signed [S_W-1:0] r_sd [4];
  logic signed [Y_W-1:0] r_y [4];
  logic signed [S_W-1:0] w_x [4];
  logic signed [S_W-1:0] w_sd [4];
  logic signed [Y_W-1:0] w_sd_ext [4];
  logic signed [Y_W-1:0] w_y [4];
  logic                  w_ld1;
  logic                  w_ld2;
  logic                  w_xfer;
  assign w_xfer = r_v2 && out_ready;
  assign w_ld2 = !r_v2 || out_ready;
  assign w_ld1 = !r_v1 || w_ld2;
  assign in_ready = rst && w_ld1;
  assign w_x = '{S_W'(x0), S_W'(x1), S_W'(x2), S_W'(x3)};
  always_comb begin
    for (int i = 0; i < 4; i++) w_sd_ext[i] = Y_W'(r_sd[i]);
  end
  dct4_butterfly #(.W(S_W), .OUT_STAGE(1'b0)) u_bf_sd (.a(w_x), .b(w_sd));
  dct4_butterfly #(.W(Y_W), .OUT_STAGE(1'b1)) u_bf_y (.a(w_sd_ext), .b(w_y));
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_cnt <= '0;
      r_done <= 1'b0;
      r_y <= '{default: '0};
    end else begin
      if (w_ld1) r_v1 <= in_valid;
      if (w_ld1 && in_valid) r_sd <= w_sd;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld2 && r_v1) r_y <= w_y;
      if (w_xfer) r_cnt <= r_cnt + 2'd1;
      r_done <= w_xfer && r_cnt == row_idx_t'(DCT_ROWS - 1);
    end
  end
  // signed casts sign-extend the Y_W-bit results to the FIFO word width
  assign y0 = OUT_W'(r_y[0]);
  assign y1 = OUT_W'(r_y[1]);
  assign y2 = OUT_W'(r_y[2]);
  assign y3 = OUT_W'(r_y[3]);
  assign out_valid = r_v2;
  assign row_idx = r_cnt;
  assign block_done = r_done;
endmodule

// File: tb/tb_dct4_row_stage.sv
// tb_dct4_row_stage: table vectors, directed stall/reset/block sequences and random traffic vs a matrix model
module tb_dct4_row_stage;
  typedef struct {
    int     x0, x1, x2, x3;
    longint y0, y1, y2, y3;
  } vec_t;
  typedef struct {
    longint y0, y1, y2, y3;
  } row_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic in_ready, out_valid, block_done;
  logic signed [35:0] y0, y1, y2, y3;
  logic [1:0] row_idx;
  int total = 0;
  int bad = 0;
  int h [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
  vec_t tv [6];
  row_t q [$];
  always #5 clk = ~clk;
  dct4_row_stage #(.IN_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .row_idx(row_idx), .block_done(block_done)
  );
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic row_t ref_row(input longint a0, input longint a1, input longint a2, input longint a3);
    longint a [4];
    longint acc [4];
    a = '{a0, a1, a2, a3};
    for (int k = 0; k < 4; k++) begin
      acc[k] = 0;
      for (int j = 0; j < 4; j++) acc[k] += h[k][j] * a[j];
    end
    return '{acc[0], acc[1], acc[2], acc[3]};
  endfunction
  task automatic put(input vec_t v);
    x0 = 16'(v.x0);
    x1 = 16'(v.x1);
    x2 = 16'(v.x2);
    x3 = 16'(v.x3);
  endtask
  task automatic chk_y(input string nm, input vec_t v);
    chk({nm, "_y0"}, y0, v.y0);
    chk({nm, "_y1"}, y1, v.y1);
    chk({nm, "_y2"}, y2, v.y2);
    chk({nm, "_y3"}, y3, v.y3);
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  // drives up to n rows with random valid/ready and scores every output against the model queue
  task automatic stream(input int n, input int pv, input int pr, input int max_cyc, output int cyc);
    int sent = 0, got = 0, exp_row = 0, blocks = 0;
    logic exp_done = 1'b0, pend = 1'b0;
    row_t e;
    cyc = 0;
    q.delete();
    while (got < n && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      chk("block_done", block_done, exp_done);
      if (block_done) blocks++;
      if (!pend && sent < n && $urandom_range(99) < pv) begin
        x0 = 16'($urandom);
        x1 = 16'($urandom);
        x2 = 16'($urandom);
        x3 = 16'($urandom);
        pend = 1'b1;
      end
      in_valid = pend;
      out_ready = $urandom_range(99) < pr;
      #1;
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("rnd_y0", y0, e.y0);
          chk("rnd_y1", y1, e.y1);
          chk("rnd_y2", y2, e.y2);
          chk("rnd_y3", y3, e.y3);
          chk("rnd_row_idx", row_idx, exp_row);
          exp_done = exp_row == 3;
          exp_row = (exp_row + 1) % 4;
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_row(x0, x1, x2, x3));
        sent++;
        pend = 1'b0;
      end
    end
    if (got < n) chk("stream_timeout", got, n);
    @(negedge clk);
    in_valid = 1'b0;
    chk("block_done_last", block_done, exp_done);
    if (block_done) blocks++;
    chk("block_count", blocks, n / 4);
    chk("rows_left", q.size(), 0);
  endtask
  initial begin
    int cyc;
    tv[0] = '{1, 2, 3, 4, 10, -7, 0, -1};
    tv[1] = '{32767, -32768, 32767, -32768, -2, 65535, 0, 196605};
    tv[2] = '{32767, 32767, 32767, 32767, 131068, 0, 0, 0};
    tv[3] = '{-32768, -32768, -32768, -32768, -131072, 0, 0, 0};
    tv[4] = '{5, -3, 7, 0, 9, 0, 1, 25};
    tv[5] = '{0, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y0", y0, 0);
    chk("rst_y3", y3, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_block_done", block_done, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);
    foreach (tv[k]) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      put(tv[k]);
      @(negedge clk);
      in_valid = 1'b0;
      chk("tbl_early_valid", out_valid, 0);
      @(negedge clk);
      chk("tbl_out_valid", out_valid, 1);
      chk_y("tbl", tv[k]);
      chk("tbl_row_idx", row_idx, k % 4);
    end
    reset_dut();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    put(tv[0]);
    #1 chk("stall_rdy0", in_ready, 1);
    @(negedge clk);
    put(tv[1]);
    #1 chk("stall_rdy1", in_ready, 1);
    @(negedge clk);
    put(tv[4]);
    #1 chk("stall_rdy2", in_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("stall_hold_rdy", in_ready, 0);
      chk("stall_hold_valid", out_valid, 1);
      chk_y("stall_hold", tv[0]);
      chk("stall_hold_idx", row_idx, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("stall_release_rdy", in_ready, 1);
    chk_y("stall_out0", tv[0]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall_v1", out_valid, 1);
    chk_y("stall_out1", tv[1]);
    chk("stall_idx1", row_idx, 1);
    @(negedge clk);
    chk("stall_v2", out_valid, 1);
    chk_y("stall_out2", tv[4]);
    chk("stall_idx2", row_idx, 2);
    @(negedge clk);
    chk("stall_drained", out_valid, 0);
    reset_dut();
    stream(8, 100, 100, 50, cyc);
    chk("block_cycles", cyc, 10);
    reset_dut();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    put(tv[0]);
    @(negedge clk);
    put(tv[4]);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1 chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y0", y0, 0);
    chk("midrst_y1", y1, 0);
    chk("midrst_row_idx", row_idx, 0);
    chk("midrst_block_done", block_done, 0);
    @(negedge clk);
    chk("midrst_flushed", out_valid, 0);
    stream(1, 100, 100, 20, cyc);
    reset_dut();
    stream(1000, 70, 60, 20000, cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dct4_row_stage.md
# dct4_row_stage

Pipelined 4-point integer DCT row stage for the 2D DCT path. It accepts one 4-sample row per handshake and applies the butterfly form of the H.264-style 4x4 core transform. It emits four sign-extended 36-bit coefficients per row, which are written as one batch into the downstream 16-entry coefficient FIFO (din0..din3 / wr_en). It also tracks row position within each 4x4 block and flags block completion.

## Interface
- IN_W, 16, signed input sample width; legal range 2..33 so IN_W+3 ≤ 36.
- OUT_W, 36, coefficient width; fixed to match the FIFO word width.

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  row x0..x3 presented
- in_ready  out  1  stage can accept a row this cycle
- x0, x1, x2, x3  in  IN_W each  signed input samples of one row
- out_valid  out  1  coefficient batch valid; drives FIFO wr_en through out_ready gating
- out_ready  in  1  downstream accepts batch; tied to !full-of-next-batch
- y0, y1, y2, y3  out  OUT_W each  signed coefficients → din0..din3
- row_idx  out  2  row number (0..3) of the batch currently on y0..y3
- block_done  out  1  one-cycle pulse after the 4th row of a block is accepted downstream

## Operation
- Stage 1 (butterfly), registered, at IN_W+1 bits: s0=x0+x3, s1=x1+x2, d0=x0−x3, d1=x1−x2.
- Stage 2 (output), registered, at IN_W+3 bits: y0=s0+s1, y2=s0−s1, y1=(d0<<1)+d1, y3=d0−(d1<<1).
  - Result is sign-extended to OUT_W. No rounding, no saturation; the width rule guarantees no overflow.
- Elastic 2-entry pipeline with per-stage valid bits v1 and v2:
  - Stage 2 loads when !v2 or (out_valid && out_ready).
  - Stage 1 loads when !v1 or stage 2 loads.
  - in_ready = rst && (!v1 || stage-2-load). Combinational, with no dependence on in_valid.
- Handshakes:
  - Input is transferred on in_valid && in_ready.
  - Output is transferred on out_valid && out_ready.
  - out_valid = v2.
- Stall behaviour: y0..y3, row_idx, and out_valid hold stable while out_valid && !out_ready.
- Row counter:
  - row_cnt (2 bits) increments on each output transfer and wraps 3→0.
  - row_idx = row_cnt.
- block_done is registered, high for exactly one cycle following a transfer with row_idx==3.
- Simultaneous input and output transfers in one cycle sustain 1 row/cycle throughput.

## Timing
- Latency: a row accepted at edge N appears on y* with out_valid=1 after edge N+2, provided there is no stall.
- Throughput: 1 row/cycle. A 4x4 block takes 4 cycles plus 2 cycles of fill.
- Reset (rst=0 at an edge) forces: v1=v2=0, out_valid=0, y0..y3=0, row_idx=0, block_done=0.
- in_ready reads 0 while rst is low, and 1 in the first cycle after release.
- Reset mid-block discards in-flight rows and restarts row numbering at 0. No block_done is issued for the partial block.
- Full pipeline with out_ready=0: in_ready=0. Inputs are not consumed and no data is lost or duplicated.
- out_ready toggling with in_valid held high: every accepted row is emitted exactly once, in order.

## Structure
- Shared package dct_pkg:
  - DCT_OUT_W=36 and DCT_ROWS=4.
  - Row-index type (2 bits).
  - Width helper constant for IN_W+3.
  - Also used by the FIFO and the column stage.
- One sub-module, dct4_butterfly: combinational s/d and y equations, parameterised on width, instantiated once per stage half.
- Pipeline registers, valid/ready control, and row counter stay in dct4_row_stage.

## Test plan
- Basic: x=(1,2,3,4), out_ready=1 → y=(10,−7,0,−1) exactly 2 cycles later; row_idx=0.
- Extremes: IN_W=16, x=(32767,−32768,32767,−32768) → y=(−2,65535,0,196605). Separately, all 32767 → y=(131068,0,0,0), with correct 36-bit sign extension.
- Stall: push 3 rows with out_ready=0 → only 2 accepted, in_ready=0 from cycle 2. Outputs hold for 5 cycles. After out_ready=1, the 3 rows emerge in order with row_idx 0,1,2.
- Block sequencing: 8 back-to-back rows, out_ready=1 → 1 row/cycle output, row_idx 0,1,2,3,0,1,2,3, block_done pulses twice, each one cycle after row_idx=3 transfers.
- Reset mid-operation: after 2 rows accepted, drop rst for 1 cycle → out_valid=0, y=0, row_idx=0. The next row is emitted with row_idx=0 and no spurious block_done.
- Random backpressure: 1000 random rows with random in_valid/out_ready → outputs match a reference model, in order, no loss or duplication, block_done count = rows/4.
